// File: rtl/interval_event_scheduler.sv
// Periodic event scheduler: per-channel microsecond period counters with optional PPS alignment,
// pending/overrun tracking and a round-robin valid/ready request port.
module interval_event_scheduler #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned PERIOD_WIDTH = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] microsecondsSinceBoot,
   input  logic        PPS,
   input  logic        csrStrobe,
   input  logic [2:0]  csrChannel,
   input  logic [31:0] csrData,
   input  logic        statusStrobe,
   input  logic [7:0]  statusData,
   output logic [31:0] status,
   output logic        reqValid,
   output logic [2:0]  reqChannel,
   output logic [31:0] reqTimestamp,
   input  logic        reqReady
);

   typedef logic [PERIOD_WIDTH-1:0] period_t;

   // Time base edge detection
   logic [31:0] us_prev_q;
   logic        pps_prev_q;
   logic        us_tick_q;
   logic        pps_edge_q;

   // Per-channel state
   logic [CHANNELS-1:0] en_q, en_d;
   logic [CHANNELS-1:0] align_q, align_d;
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] ovr_q, ovr_d;
   period_t             period_q [CHANNELS];
   period_t             period_d [CHANNELS];
   period_t             cnt_q [CHANNELS];
   period_t             cnt_d [CHANNELS];
   logic [31:0]         ts_q [CHANNELS];
   logic [31:0]         ts_d [CHANNELS];

   logic [CHANNELS-1:0] csr_hit;
   logic [CHANNELS-1:0] pps_reload;
   logic [CHANNELS-1:0] run;
   logic [CHANNELS-1:0] expire;
   logic [CHANNELS-1:0] ovr_set;

   // Arbiter and output register
   logic                req_valid_q, req_valid_d;
   logic [2:0]          req_ch_q, req_ch_d;
   logic [31:0]         req_ts_q, req_ts_d;
   logic [2:0]          last_grant_q, last_grant_d;
   logic                load_out;
   logic                gnt_found;
   logic [2:0]          gnt_idx;
   logic [31:0]         sel_ts;
   logic [CHANNELS-1:0] grant;

   logic [31:0]         status_q, status_d;
   logic [7:0]          en8, pend8, ovr8;

   // Round-robin search: channels above lastGrant first, then wrap to the rest.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!gnt_found && pend_q[i] && (i > int'(last_grant_q))) begin
            gnt_found = 1'b1;
            gnt_idx   = 3'(i);
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (!gnt_found && pend_q[i] && (i <= int'(last_grant_q))) begin
            gnt_found = 1'b1;
            gnt_idx   = 3'(i);
         end
      end
   end

   always_comb begin
      load_out     = !req_valid_q || reqReady;
      grant        = '0;
      sel_ts       = '0;
      req_valid_d  = req_valid_q;
      req_ch_d     = req_ch_q;
      req_ts_d     = req_ts_q;
      last_grant_d = last_grant_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (gnt_idx == 3'(i)) begin
            sel_ts = ts_q[i];
         end
         grant[i] = load_out && gnt_found && (gnt_idx == 3'(i));
      end
      if (load_out) begin
         if (gnt_found) begin
            req_valid_d  = 1'b1;
            req_ch_d     = gnt_idx;
            req_ts_d     = sel_ts;
            last_grant_d = gnt_idx;
         end else begin
            req_valid_d  = 1'b0;
         end
      end
   end

   always_comb begin
      en_d       = en_q;
      align_d    = align_q;
      pend_d     = pend_q;
      ovr_d      = ovr_q;
      period_d   = period_q;
      cnt_d      = cnt_q;
      ts_d       = ts_q;
      csr_hit    = '0;
      pps_reload = '0;
      run        = '0;
      expire     = '0;
      ovr_set    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         csr_hit[i]    = csrStrobe && (csrChannel == 3'(i));
         pps_reload[i] = align_q[i] && pps_edge_q;
         run[i]        = en_q[i] && (period_q[i] != '0) && us_tick_q;
         // CSR write and PPS reload both suppress a same-cycle expiry.
         expire[i]     = run[i] && (cnt_q[i] == period_t'(1)) && !pps_reload[i] && !csr_hit[i];

         if (csr_hit[i]) begin
            en_d[i]     = csrData[31];
            align_d[i]  = csrData[30];
            period_d[i] = csrData[PERIOD_WIDTH-1:0];
            cnt_d[i]    = csrData[PERIOD_WIDTH-1:0];
         end else if (pps_reload[i]) begin
            cnt_d[i]    = period_q[i];
         end else if (run[i]) begin
            cnt_d[i]    = (cnt_q[i] == period_t'(1)) ? period_q[i] : cnt_q[i] - period_t'(1);
         end

         if (csr_hit[i] && !csrData[31]) begin
            pend_d[i] = 1'b0;
         end else if (expire[i]) begin
            if (pend_q[i] && !grant[i]) begin
               ovr_set[i] = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
               ts_d[i]   = microsecondsSinceBoot;
            end
         end else if (grant[i]) begin
            pend_d[i] = 1'b0;
         end

         ovr_d[i] = (ovr_q[i] && !(statusStrobe && statusData[i])) || ovr_set[i];
      end
   end

   always_comb begin
      en8                 = '0;
      pend8               = '0;
      ovr8                = '0;
      en8[CHANNELS-1:0]   = en_q;
      pend8[CHANNELS-1:0] = pend_q;
      ovr8[CHANNELS-1:0]  = ovr_q;
      status_d            = {8'h00, en8, pend8, ovr8};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         us_prev_q    <= microsecondsSinceBoot;
         pps_prev_q   <= PPS;
         us_tick_q    <= 1'b0;
         pps_edge_q   <= 1'b0;
         en_q         <= '0;
         align_q      <= '0;
         pend_q       <= '0;
         ovr_q        <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            period_q[i] <= '0;
            cnt_q[i]    <= '0;
            ts_q[i]     <= '0;
         end
         req_valid_q  <= 1'b0;
         req_ch_q     <= '0;
         req_ts_q     <= '0;
         last_grant_q <= 3'(CHANNELS - 1);
         status_q     <= '0;
      end else begin
         us_prev_q    <= microsecondsSinceBoot;
         pps_prev_q   <= PPS;
         us_tick_q    <= (microsecondsSinceBoot != us_prev_q);
         pps_edge_q   <= PPS && !pps_prev_q;
         en_q         <= en_d;
         align_q      <= align_d;
         pend_q       <= pend_d;
         ovr_q        <= ovr_d;
         for (int i = 0; i < CHANNELS; i++) begin
            period_q[i] <= period_d[i];
            cnt_q[i]    <= cnt_d[i];
            ts_q[i]     <= ts_d[i];
         end
         req_valid_q  <= req_valid_d;
         req_ch_q     <= req_ch_d;
         req_ts_q     <= req_ts_d;
         last_grant_q <= last_grant_d;
         status_q     <= status_d;
      end
   end

   assign status       = status_q;
   assign reqValid     = req_valid_q;
   assign reqChannel   = req_ch_q;
   assign reqTimestamp = req_ts_q;

endmodule

// File: tb/tb_interval_event_scheduler.sv
// Directed bench for interval_event_scheduler: hand-computed request sequences, timestamps and
// status words across period, round-robin, overrun, PPS, disable, reset and wrap scenarios.
module tb_interval_event_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] us;
   logic        pps;
   logic        csr_strobe;
   logic [2:0]  csr_channel;
   logic [31:0] csr_data;
   logic        status_strobe;
   logic [7:0]  status_data;
   logic [31:0] status;
   logic        req_valid;
   logic [2:0]  req_channel;
   logic [31:0] req_timestamp;
   logic        req_ready;

   int checks = 0;
   int failures = 0;
   int cyc_cnt = 0;
   int valid_cycles = 0;
   int base;
   int vbase;

   logic [2:0]  log_ch[$];
   logic [31:0] log_ts[$];
   int          log_cy[$];

   interval_event_scheduler #(
      .CHANNELS     (4),
      .PERIOD_WIDTH (24)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .microsecondsSinceBoot (us),
      .PPS                   (pps),
      .csrStrobe             (csr_strobe),
      .csrChannel            (csr_channel),
      .csrData               (csr_data),
      .statusStrobe          (status_strobe),
      .statusData            (status_data),
      .status                (status),
      .reqValid              (req_valid),
      .reqChannel            (req_channel),
      .reqTimestamp          (req_timestamp),
      .reqReady              (req_ready)
   );

   always #5 clk = ~clk;

   // Handshakes observed at the negedge complete on the following posedge.
   always @(negedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (rst === 1'b0 && req_valid === 1'b1) begin
         valid_cycles <= valid_cycles + 1;
         if (req_ready === 1'b1) begin
            log_ch.push_back(req_channel);
            log_ts.push_back(req_timestamp);
            log_cy.push_back(cyc_cnt);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lts(input int i);
      return (i < log_ts.size()) ? log_ts[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] lch(input int i);
      return (i < log_ch.size()) ? 32'(log_ch[i]) : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] lcy(input int i);
      return (i < log_cy.size()) ? 32'(log_cy[i]) : 32'hxxxx_xxxx;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [31:0] start_us);
      us  = start_us;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic csr(input logic [2:0] ch, input logic [31:0] data);
      csr_strobe  = 1'b1;
      csr_channel = ch;
      csr_data    = data;
      cyc(1);
      csr_strobe  = 1'b0;
   endtask

   task automatic step(input logic [31:0] v);
      us = v;
      cyc(5);
   endtask

   initial begin
      rst = 1'b1; us = '0; pps = 1'b0; csr_strobe = 1'b0; csr_channel = '0; csr_data = '0;
      status_strobe = 1'b0; status_data = '0; req_ready = 1'b0;
      cyc(2);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(req_valid), 32'd0);
      chk("rst_channel", 32'(req_channel), 32'd0);
      chk("rst_timestamp", req_timestamp, 32'd0);
      chk("rst_status", status, 32'd0);
      cyc(1);

      // Basic period 3 from us 100, with exact latency around the first expiry
      do_reset(32'd100);
      req_ready = 1'b1;
      base = log_ts.size();
      vbase = valid_cycles;
      csr(3'd0, 32'h8000_0003);
      step(32'd101);
      step(32'd102);
      us = 32'd103;
      cyc(2);
      @(negedge clk);
      chk("lat_pending_only", 32'(req_valid), 32'd0);
      cyc(1);
      @(negedge clk);
      chk("lat_valid", 32'(req_valid), 32'd1);
      chk("lat_channel", 32'(req_channel), 32'd0);
      chk("lat_timestamp", req_timestamp, 32'd103);
      cyc(1);
      @(negedge clk);
      chk("lat_drop", 32'(req_valid), 32'd0);
      cyc(1);
      for (int v = 104; v <= 110; v++) step(32'(v));
      cyc(2);
      chk("basic_count", 32'(log_ts.size() - base), 32'd3);
      chk("basic_ts0", lts(base), 32'd103);
      chk("basic_ts1", lts(base + 1), 32'd106);
      chk("basic_ts2", lts(base + 2), 32'd109);
      chk("basic_ch2", lch(base + 2), 32'd0);
      chk("basic_valid_cycles", 32'(valid_cycles - vbase), 32'd3);
      chk("basic_status", status, 32'h0001_0000);

      // Round-robin: four channels, period 2, expiring together
      do_reset(32'd110);
      req_ready = 1'b1;
      base = log_ts.size();
      csr(3'd0, 32'h8000_0002);
      csr(3'd1, 32'h8000_0002);
      csr(3'd2, 32'h8000_0002);
      csr(3'd3, 32'h8000_0002);
      for (int v = 111; v <= 116; v++) step(32'(v));
      cyc(6);
      chk("rr_count", 32'(log_ts.size() - base), 32'd12);
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("rr_ch%0d", k), lch(base + k), 32'(k % 4));
         chk($sformatf("rr_ts%0d", k), lts(base + k), 32'(112 + 2 * (k / 4)));
      end
      chk("rr_back_to_back", lcy(base + 3) - lcy(base), 32'd3);
      chk("rr_status", status, 32'h000F_0000);

      // Overrun: channel 1 period 2 with the consumer stalled for 10 us
      do_reset(32'd200);
      req_ready = 1'b0;
      base = log_ts.size();
      csr(3'd1, 32'h8000_0002);
      for (int v = 201; v <= 210; v++) step(32'(v));
      @(negedge clk);
      chk("ovr_valid_held", 32'(req_valid), 32'd1);
      chk("ovr_channel_held", 32'(req_channel), 32'd1);
      chk("ovr_ts_held", req_timestamp, 32'd202);
      chk("ovr_status", status, 32'h0002_0202);
      cyc(1);
      req_ready = 1'b1;
      cyc(4);
      chk("ovr_drain_count", 32'(log_ts.size() - base), 32'd2);
      chk("ovr_drain_ts0", lts(base), 32'd202);
      chk("ovr_drain_ts1", lts(base + 1), 32'd204);
      chk("ovr_status_sticky", status, 32'h0002_0002);
      status_strobe = 1'b1;
      status_data   = 8'h02;
      cyc(1);
      status_strobe = 1'b0;
      cyc(2);
      chk("ovr_status_cleared", status, 32'h0002_0000);

      // PPS alignment: channel 2 period 10, PPS rising with us 507
      do_reset(32'd500);
      req_ready = 1'b1;
      base = log_ts.size();
      csr(3'd2, 32'hC000_000A);
      for (int v = 501; v <= 506; v++) step(32'(v));
      us  = 32'd507;
      pps = 1'b1;
      cyc(5);
      pps = 1'b0;
      for (int v = 508; v <= 528; v++) step(32'(v));
      cyc(6);
      chk("pps_count", 32'(log_ts.size() - base), 32'd2);
      chk("pps_ts0", lts(base), 32'd517);
      chk("pps_ts1", lts(base + 1), 32'd527);
      chk("pps_ch0", lch(base), 32'd2);
      chk("pps_status", status, 32'h0004_0000);

      // Disable while pending: ch0 occupies the stalled output, ch3 waits
      do_reset(32'd600);
      req_ready = 1'b0;
      base = log_ts.size();
      csr(3'd0, 32'h8000_0002);
      csr(3'd3, 32'h8000_0002);
      step(32'd601);
      step(32'd602);
      chk("dis_status_before", status, 32'h0009_0800);
      chk("dis_out_channel", 32'(req_channel), 32'd0);
      csr(3'd3, 32'h0000_0002);
      cyc(2);
      chk("dis_status_after", status, 32'h0001_0000);
      req_ready = 1'b1;
      for (int v = 603; v <= 606; v++) step(32'(v));
      cyc(6);
      chk("dis_count", 32'(log_ts.size() - base), 32'd3);
      chk("dis_ch0", lch(base), 32'd0);
      chk("dis_ch1", lch(base + 1), 32'd0);
      chk("dis_ch2", lch(base + 2), 32'd0);
      chk("dis_ts2", lts(base + 2), 32'd606);

      // Reset while a request is being offered
      do_reset(32'd700);
      req_ready = 1'b0;
      csr(3'd1, 32'h8000_0002);
      step(32'd701);
      step(32'd702);
      chk("mid_valid_before", 32'(req_valid), 32'd1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_valid_after", 32'(req_valid), 32'd0);
      chk("mid_status_after", status, 32'd0);
      cyc(1);
      req_ready = 1'b1;
      base = log_ts.size();
      for (int v = 703; v <= 708; v++) step(32'(v));
      chk("mid_quiet", 32'(log_ts.size() - base), 32'd0);
      chk("mid_quiet_status", status, 32'd0);
      csr(3'd2, 32'h8000_0002);
      csr(3'd1, 32'h8000_0002);
      step(32'd709);
      step(32'd710);
      cyc(4);
      chk("mid_regrant_count", 32'(log_ts.size() - base), 32'd2);
      chk("mid_first_lowest", lch(base), 32'd1);
      chk("mid_second", lch(base + 1), 32'd2);
      chk("mid_ts", lts(base), 32'd710);

      // Wrap-around, period 0 and an out-of-range channel write
      do_reset(32'hFFFF_FFFE);
      req_ready = 1'b1;
      base = log_ts.size();
      csr(3'd0, 32'h8000_0002);
      csr(3'd1, 32'h8000_0000);
      csr(3'd4, 32'h8000_0001);
      cyc(2);
      chk("wrap_status_en", status, 32'h0003_0000);
      step(32'hFFFF_FFFF);
      step(32'h0000_0000);
      step(32'h0000_0001);
      step(32'h0000_0002);
      cyc(2);
      chk("wrap_count", 32'(log_ts.size() - base), 32'd2);
      chk("wrap_ts0", lts(base), 32'd0);
      chk("wrap_ts1", lts(base + 1), 32'd2);
      chk("wrap_ch1", lch(base + 1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interval_event_scheduler.md
Name: interval_event_scheduler

Overview:
- Turns the free-running time base from the clock-interval counters (microsecondsSinceBoot, PPS) into periodic software-programmed event requests.
- Has CHANNELS independent channels, each with its own period in microseconds and optional PPS alignment.
- Expired channels queue as pending requests. A round-robin arbiter shares one valid/ready request port among them; that port feeds the event injector downstream.

Parameters:
CHANNELS, 4, number of scheduler channels (1..8)
PERIOD_WIDTH, 24, width of per-channel period in microseconds

Ports:
clk  input  1  system clock, same domain as the interval counters
rst  input  1  synchronous, active-high reset
microsecondsSinceBoot  input  32  time base from the interval counters
PPS  input  1  pulse-per-second from the interval counters (level, rising edge used)
csrStrobe  input  1  one-cycle channel configuration write
csrChannel  input  3  channel index for csrStrobe; values >= CHANNELS are ignored
csrData  input  32  bit31 enable, bit30 alignPPS, bits[PERIOD_WIDTH-1:0] period
statusStrobe  input  1  one-cycle write-1-to-clear of overrun bits
statusData  input  8  overrun clear mask
status  output  32  [7:0] overrun sticky, [15:8] pending, [23:16] enable, rest 0
reqValid  output  1  request available
reqChannel  output  3  channel of the current request
reqTimestamp  output  32  microsecondsSinceBoot value at which the request expired
reqReady  input  1  consumer accepts the request when reqValid && reqReady

Behaviour:
- Reset (rst high at a clk edge) clears all state:
  - all outputs 0
  - all channels disabled; counters, pending and overrun 0
  - usPrev = microsecondsSinceBoot; ppsPrev = PPS
  - lastGrant = CHANNELS-1, so channel 0 has first priority
- Rst wins over every other event in the same cycle, including a request handshake in progress.
- usTick is registered and equals (microsecondsSinceBoot != usPrev). It is asserted for one cycle per microsecond step.
- ppsEdge is registered and equals PPS && !ppsPrev.
- Channel counter, on a usTick cycle when enabled and period != 0:
  - counter == 1: the channel expires. It sets pending on the next edge, captures reqTimestamp as the current microsecondsSinceBoot, and reloads the counter to period.
  - otherwise: counter decrements.
- Period 0 never expires, even when enabled.
- alignPPS channels on an ppsEdge cycle: the counter reloads to period. No expiry occurs in that cycle even if usTick is also asserted; the PPS reload wins.
- csrStrobe on a valid channel:
  - loads enable, alignPPS and period
  - loads counter = period, so the first expiry is period microseconds later
  - with enable=0, also clears that channel's pending bit
- csrStrobe has priority over a same-cycle expiry on that channel.
- Overrun:
  - Trigger: a channel expires while its pending bit is already set and it is not being granted in the same cycle.
  - Effect: the overrun sticky bit is set. The pending bit stays set and keeps the older timestamp.
  - Clearing: the bit clears only via statusStrobe with the matching statusData bit. If a set and a clear land in the same cycle, the set wins.
- Arbiter:
  - Output register loads when !reqValid || reqReady.
  - Search order starts at lastGrant+1 and wraps modulo CHANNELS; the first pending channel found is granted.
  - On a grant: reqValid=1 and reqChannel/reqTimestamp are loaded; that pending bit is cleared; lastGrant is updated. All on the same edge.
  - If nothing is pending, reqValid goes to 0 at the edge where the handshake completes.
  - Latency: expiry cycle -> pending set (+1) -> reqValid (+2 clk) when the output is free.
  - Throughput: one request per clk when reqReady is held high.
- Hold rule: while reqValid && !reqReady, reqChannel and reqTimestamp are held stable.
- Grant and new expiry on the same channel in the same cycle: pending stays set, with the new timestamp, and no overrun.
- usTick wrap-around of microsecondsSinceBoot (0xFFFFFFFF -> 0) is an ordinary tick.
- Status reflects registered state with one cycle of latency.

Test Plan:
- Basic period: microsecondsSinceBoot steps every 5 clk; ch0 written with enable=1, period=3 at µs 100; reqReady=1.
  -> requests on ch0 with timestamps 103, 106, 109; reqValid high for 1 clk each; no overrun.
- Round-robin: ch0..3 all period=2, written in one clk sequence; reqReady=1.
  -> reqChannel order 0,1,2,3 on consecutive clks each expiry; no channel granted twice before the others.
- Overrun: ch1 period=2; reqReady=0 for 10 µs.
  -> reqValid held with reqChannel=1 and the first timestamp unchanged; status[1]=1 and status[9]=1.
  -> After reqReady=1: one further request. statusStrobe with statusData=0x02 -> status[1]=0.
- PPS alignment: ch2 alignPPS=1, period=10; PPS rising edge at µs 507.
  -> no expiry between 507 and 516; request timestamp 517, then 527.
- Disable with pending: ch3 pending while reqReady=0 and another channel occupies the output; then write ch3 enable=0.
  -> status[11]=0, status[19]=0; ch3 is never granted.
- Reset mid-operation: rst high for 1 clk while reqValid=1.
  -> next cycle reqValid=0 and status=0; no requests afterwards until channels are reconfigured; the first grant after reconfiguration goes to the lowest pending channel.
